// File: rtl/butterfly_input_sequencer.sv
// Radix-2 DIF front end: pairs x[k] with x[k+N/2] and the matching twiddle for a butterfly.
// Latency: 1 cycle from an accepted second-half sample to OutValid.
// Backpressure: none; InValid low stalls all state and OutValid drops on the next edge.
//
// Ports:
//   Clk        rising-edge clock
//   Rst        synchronous, active-high reset (wins over InValid)
//   In         input sample {re[31:16], im[15:0]}, signed Q1.15
//   InValid    In is accepted on this edge when high
//   A          x[k]      to the butterfly
//   B          x[k+N/2]  to the butterfly
//   w          twiddle W_N^k = {cos, -sin}, Q1.15
//   OutValid   A/B/w/K valid this cycle
//   K          butterfly index k (0..N/2-1)
//   FrameDone  1-cycle pulse alongside the last pair of a frame (k = N/2-1)
module butterfly_input_sequencer #(
    parameter int N    = 8,
    parameter int LOGN = 3
) (
    input  logic            Clk,
    input  logic            Rst,
    input  logic [31:0]     In,
    input  logic            InValid,
    output logic [31:0]     A,
    output logic [31:0]     B,
    output logic [31:0]     w,
    output logic            OutValid,
    output logic [LOGN-1:0] K,
    output logic            FrameDone
);

    localparam int HALF   = N / 2;
    // The ROM holds the 16-point twiddles; smaller frames step through it.
    localparam int STRIDE = 16 / N;

    localparam logic [LOGN-1:0] HALF_CNT = LOGN'(HALF);
    localparam logic [LOGN-1:0] LAST_CNT = LOGN'(N - 1);

    logic [LOGN-1:0] cnt;
    logic [31:0]     sr [HALF];
    logic            pair_phase;
    logic [LOGN-1:0] k_idx;
    logic [2:0]      rom_idx;
    logic [31:0]     rom_w;

    // Position within the frame decides the phase; no separate state needed.
    always_comb begin
        pair_phase = (cnt >= HALF_CNT);
        k_idx      = cnt - HALF_CNT;
        rom_idx    = 3'(int'(k_idx) * STRIDE);
    end

    // Twiddle ROM for the 16-point transform, entries j = 0..7.
    always_comb begin
        rom_w = 32'h7FFF_0000;
        case (rom_idx)
            3'd0: rom_w = 32'h7FFF_0000;
            3'd1: rom_w = 32'h7641_CF05;
            3'd2: rom_w = 32'h5A82_A57E;
            3'd3: rom_w = 32'h30FB_89BF;
            3'd4: rom_w = 32'h0000_8001;
            3'd5: rom_w = 32'hCF05_89BF;
            3'd6: rom_w = 32'hA57E_A57E;
            3'd7: rom_w = 32'h89BF_CF05;
            default: rom_w = 32'h7FFF_0000;
        endcase
    end

    // Delay line of depth N/2. Every accepted sample is shifted in, including
    // the second-half ones, so the oldest tap is always x[cnt - N/2] during the
    // pair phase. Contents are deliberately not reset: the next frame's fill
    // phase overwrites every slot before it is read.
    always_ff @(posedge Clk) begin
        if (!Rst && InValid) begin
            sr[0] <= In;
            for (int i = 1; i < HALF; i++) begin
                sr[i] <= sr[i-1];
            end
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            cnt       <= '0;
            A         <= '0;
            B         <= '0;
            w         <= '0;
            K         <= '0;
            OutValid  <= 1'b0;
            FrameDone <= 1'b0;
        end else begin
            OutValid  <= 1'b0;
            FrameDone <= 1'b0;
            if (InValid) begin
                // N is a power of two, so natural wrap gives the mod-N count.
                cnt <= cnt + LOGN'(1);
                if (pair_phase) begin
                    A         <= sr[HALF-1];
                    B         <= In;
                    w         <= rom_w;
                    K         <= k_idx;
                    OutValid  <= 1'b1;
                    FrameDone <= (cnt == LAST_CNT);
                end
            end
        end
    end

endmodule

// File: tb/tb_butterfly_input_sequencer.sv
// Directed bench for butterfly_input_sequencer with N = 8.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// A vector table covers reset and contiguous frames; hand sequences cover stall, reset and chaining.
module tb_butterfly_input_sequencer;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic [31:0] In = '0;
    logic        InValid = 1'b0;
    logic [31:0] A, B, w;
    logic        OutValid;
    logic [2:0]  K;
    logic        FrameDone;

    int n_checks = 0;
    int n_fail   = 0;

    butterfly_input_sequencer #(.N(8), .LOGN(3)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .In        (In),
        .InValid   (InValid),
        .A         (A),
        .B         (B),
        .w         (w),
        .OutValid  (OutValid),
        .K         (K),
        .FrameDone (FrameDone)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic        rst;
        logic        vld;
        logic [31:0] din;
        logic        ov;
        logic        fd;
        logic        cd;   // compare A/B/w/K too
        logic [2:0]  k;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] wv;
    } vec_t;

    vec_t vecs[$];

    // Expected twiddles for N = 8, k = 0..3 (16-point ROM entries 0, 2, 4, 6).
    logic [31:0] w8 [4] = '{32'h7FFF_0000, 32'h5A82_A57E, 32'h0000_8001, 32'hA57E_A57E};

    function automatic logic [31:0] s(input int n);
        return {16'(n), 16'h0000};
    endfunction

    task automatic add(input logic rst, input logic vld, input logic [31:0] din,
                       input logic ov, input logic fd, input logic cd, input logic [2:0] k,
                       input logic [31:0] a, input logic [31:0] b, input logic [31:0] wv);
        vec_t v;
        v.rst = rst; v.vld = vld; v.din = din; v.ov = ov; v.fd = fd; v.cd = cd;
        v.k = k; v.a = a; v.b = b; v.wv = wv;
        vecs.push_back(v);
    endtask

    // Expected outputs after accepting sample position pos (1..8) of a frame
    // whose first sample has real part base.
    task automatic add_frame_pos(input int pos, input int base);
        if (pos <= 4)
            add(1'b0, 1'b1, s(base + pos - 1), 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
        else
            add(1'b0, 1'b1, s(base + pos - 1), 1'b1, (pos == 8), 1'b1, 3'(pos - 5),
                s(base + pos - 5), s(base + pos - 1), w8[pos-5]);
    endtask

    task automatic step(input logic rst, input logic vld, input logic [31:0] din);
        @(negedge Clk);
        Rst     = rst;
        InValid = vld;
        In      = din;
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string name, input logic ov, input logic fd, input logic cd,
                         input logic [2:0] k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] wv);
        logic ok;
        n_checks++;
        ok = (OutValid === ov) && (FrameDone === fd);
        if (cd) ok = ok && (K === k) && (A === a) && (B === b) && (w === wv);
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got ov=%b fd=%b K=%0d A=%h B=%h w=%h, want ov=%b fd=%b K=%0d A=%h B=%h w=%h (data %s)",
                     name, OutValid, FrameDone, K, A, B, w, ov, fd, k, a, b, wv,
                     cd ? "checked" : "ignored");
        end
    endtask

    task automatic check_reset(input string name);
        check(name, 1'b0, 1'b0, 1'b1, 3'd0, '0, '0, '0);
    endtask

    // Feed frame position pos (value base+pos-1) and check the expected result.
    task automatic feed(input string tag, input int pos, input int base);
        step(1'b0, 1'b1, s(base + pos - 1));
        if (pos <= 4)
            check($sformatf("%s_pos%0d", tag, pos), 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
        else
            check($sformatf("%s_pos%0d", tag, pos), 1'b1, (pos == 8), 1'b1, 3'(pos - 5),
                  s(base + pos - 5), s(base + pos - 1), w8[pos-5]);
    endtask

    // Behavioural multiply-add unit: Y = A + w*B, Z = A - w*B, Q1.15 with rounding.
    function automatic logic signed [15:0] qmul(input logic signed [15:0] x, input logic signed [15:0] y);
        int p;
        p = int'(x) * int'(y);
        return 16'((p + 16384) >>> 15);
    endfunction

    task automatic mau(input logic [31:0] a, input logic [31:0] b, input logic [31:0] wv,
                       output logic [31:0] y, output logic [31:0] z);
        logic signed [15:0] wbr, wbi;
        wbr = qmul(wv[31:16], b[31:16]) - qmul(wv[15:0], b[15:0]);
        wbi = qmul(wv[31:16], b[15:0]) + qmul(wv[15:0], b[31:16]);
        y = {a[31:16] + wbr, a[15:0] + wbi};
        z = {a[31:16] - wbr, a[15:0] - wbi};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] y, z, ey, ez;
        int frame6 [8] = '{1, 0, 0, 0, 1, 0, 0, 0};

        // Test 1: two reset cycles with InValid high.
        add(1'b1, 1'b1, s(99), 1'b0, 1'b0, 1'b1, 3'd0, '0, '0, '0);
        add(1'b1, 1'b1, s(98), 1'b0, 1'b0, 1'b1, 3'd0, '0, '0, '0);
        // Tests 2 and 3: frames 1..8 and 9..16 back to back.
        for (int p = 1; p <= 8; p++) add_frame_pos(p, 1);
        for (int p = 1; p <= 8; p++) add_frame_pos(p, 9);
        // Idle cycle: valid must drop.
        add(1'b0, 1'b0, s(77), 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].rst, vecs[i].vld, vecs[i].din);
            check($sformatf("vec%0d", i), vecs[i].ov, vecs[i].fd, vecs[i].cd,
                  vecs[i].k, vecs[i].a, vecs[i].b, vecs[i].wv);
        end

        // Test 4: stall of 3 cycles after sample 6.
        step(1'b1, 1'b0, '0);
        check_reset("stall_rst");
        for (int p = 1; p <= 6; p++) feed("stall", p, 1);
        for (int g = 0; g < 3; g++) begin
            step(1'b0, 1'b0, s(55));
            check($sformatf("stall_gap%0d", g), 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
        end
        for (int p = 7; p <= 8; p++) feed("stall", p, 1);

        // Test 5: reset after sample 6, with InValid high on the reset cycle.
        for (int p = 1; p <= 6; p++) feed("midrst", p, 1);
        step(1'b1, 1'b1, s(7));
        check_reset("midrst_rst");
        for (int p = 1; p <= 8; p++) feed("fresh", p, 21);

        // Test 6: chain into a multiply-add model, x = 1,0,0,0,1,0,0,0.
        for (int p = 1; p <= 8; p++) begin
            step(1'b0, 1'b1, s(frame6[p-1]));
            if (p <= 4) begin
                check($sformatf("mau_fill%0d", p), 1'b0, 1'b0, 1'b0, 3'd0, '0, '0, '0);
            end else begin
                check($sformatf("mau_pair%0d", p - 5), 1'b1, (p == 8), 1'b1, 3'(p - 5),
                      s(frame6[p-5]), s(frame6[p-1]), w8[p-5]);
                mau(A, B, w, y, z);
                ey = (p == 5) ? s(2) : 32'h0;
                ez = 32'h0;
                n_checks++;
                if (y !== ey || z !== ez) begin
                    n_fail++;
                    $display("FAIL mau_yz_k%0d: got Y=%h Z=%h, want Y=%h Z=%h", p - 5, y, z, ey, ez);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
